// File: rtl/bus_memory_target.sv
// Target end of the MMU's 64-bit physical memory bus: single-beat reads and
// writes into a word-addressed RAM with a fixed, parameterised access latency.
module bus_memory_target #(
    parameter int unsigned                      PHYSICAL_ADDRESS_SIZE = 56,
    parameter int unsigned                      DEPTH_WORDS           = 1024,
    parameter logic [PHYSICAL_ADDRESS_SIZE-1:0] BASE_ADDRESS          = '0,
    parameter int unsigned                      LATENCY               = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PHYSICAL_ADDRESS_SIZE-1:0] addressBus,
    input  logic [63:0]                      dataIn,
    input  logic                             enableWrite,
    input  logic                             reqValid,
    output logic [63:0]                      dataOut,
    output logic                             respValid,
    output logic                             respError,
    output logic                             busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [PHYSICAL_ADDRESS_SIZE-1:0] SPAN =
        PHYSICAL_ADDRESS_SIZE'(DEPTH_WORDS) << 3;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [63:0]      data_out_q, data_out_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_error_q, resp_error_d;
    logic             busy_q, busy_d;

    logic [63:0]      mem_q [DEPTH_WORDS];
    logic             mem_we;

    logic [PHYSICAL_ADDRESS_SIZE-1:0] offset;
    logic                             in_range;
    logic                             misaligned;

    // The >= test keeps addresses below the base from wrapping into range
    // through the unsigned subtraction.
    always_comb begin
        offset     = addressBus - BASE_ADDRESS;
        in_range   = (addressBus >= BASE_ADDRESS) && (offset < SPAN);
        misaligned = |addressBus[2:0];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        err_d        = err_q;
        data_out_d   = data_out_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        busy_d       = busy_q;
        mem_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    index_d = offset[IDX_W+2:3];
                    wdata_d = dataIn;
                    we_d    = enableWrite;
                    err_d   = !in_range || misaligned;
                    cnt_d   = LAT_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = err_q;
                    busy_d       = 1'b0;
                    if (err_q) begin
                        data_out_d = '0;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_out_d = mem_q[index_q];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset also gates the RAM write so an aborted write never commits.
        if (rst) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            data_out_d   = '0;
            resp_valid_d = 1'b0;
            resp_error_d = 1'b0;
            busy_d       = 1'b0;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        index_q      <= index_d;
        wdata_q      <= wdata_d;
        we_q         <= we_d;
        err_q        <= err_d;
        data_out_q   <= data_out_d;
        resp_valid_q <= resp_valid_d;
        resp_error_q <= resp_error_d;
        busy_q       <= busy_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[index_q] <= wdata_q;
        end
    end

    assign dataOut   = data_out_q;
    assign respValid = resp_valid_q;
    assign respError = resp_error_q;
    assign busy      = busy_q;

endmodule
